mul4_fitness_scorer: RTL

MUL4_FITNESS_SCORER -- requirements
Module: mul4_fitness_scorer

---
 rtl/mul4_fitness_scorer_pkg.sv | 22 ++
 rtl/mul4_fitness_scorer_mul.sv | 52 +++++
 rtl/mul4_fitness_scorer.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/mul4_fitness_scorer_pkg.sv
// Shared types and constants for the multiplier fitness scorer.
package mul4_fitness_scorer_pkg;

    localparam int          WORD_W            = 16;
    localparam int          VEC_W             = 64;
    localparam logic [31:0] LFSR_POLY_DEFAULT = 32'h80200003;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GEN_A,
        S_GEN_B,
        S_MUL,
        S_CMP,
        S_DONE
    } state_t;

    // Right-shifting Galois step: taps applied when the bit shifted out is 1.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s, input logic [31:0] poly);
        return s[0] ? ({1'b0, s[31:1]} ^ poly) : {1'b0, s[31:1]};
    endfunction

endpackage

// File: rtl/mul4_fitness_scorer_mul.sv
// Golden 32x32 unsigned shift-add multiplier, one multiplier bit per cycle, LSB first.
module mul32_shift_add
    import mul4_fitness_scorer_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      a,
    input  logic [31:0]      b,
    output logic             done,
    output logic [VEC_W-1:0] product
);

    logic [VEC_W-1:0] mcand;
    logic [31:0]      mplier;
    logic [4:0]       cnt;
    logic             running;

    // Bit 0 is consumed in the start cycle, so the product is final when done rises,
    // 32 cycles after start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            product <= '0;
            mcand   <= '0;
            mplier  <= '0;
            cnt     <= '0;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                product <= b[0] ? {32'b0, a} : '0;
                mcand   <= {31'b0, a, 1'b0};
                mplier  <= {1'b0, b[31:1]};
                cnt     <= 5'd1;
                running <= 1'b1;
            end else if (running) begin
                if (mplier[0]) begin
                    product <= product + mcand;
                end
                mcand  <= mcand << 1;
                mplier <= {1'b0, mplier[31:1]};
                cnt    <= cnt + 5'd1;
                if (cnt == 5'd31) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mul4_fitness_scorer.sv
// Scores a combinational 32x32 multiplier candidate against a golden shift-add model.
// state  | meaning
// IDLE   | waiting for start
// GEN_A  | step LFSR, load operand a
// GEN_B  | step LFSR, load operand b, launch golden multiply
// MUL    | golden multiply in progress (32 cycles)
// CMP    | score candidate result, count down vectors
// DONE   | one-cycle completion pulse
module mul4_fitness_scorer
    import mul4_fitness_scorer_pkg::*;
#(
    parameter logic [31:0] LFSR_POLY = LFSR_POLY_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [15:0]       num_vectors,
    input  logic [31:0]       seed,
    output logic [WORD_W-1:0] a1,
    output logic [WORD_W-1:0] a0,
    output logic [WORD_W-1:0] b1,
    output logic [WORD_W-1:0] b0,
    input  logic [WORD_W-1:0] y3,
    input  logic [WORD_W-1:0] y2,
    input  logic [WORD_W-1:0] y1,
    input  logic [WORD_W-1:0] y0,
    output logic              busy,
    output logic              done,
    output logic [31:0]       score,
    output logic [15:0]       exact_count
);

    state_t           state, state_nxt;
    logic [31:0]      lfsr, lfsr_nxt;
    logic [31:0]      a_reg, b_reg;
    logic [15:0]      remaining;
    logic [VEC_W-1:0] y, product, match;
    logic [6:0]       match_cnt;
    logic             mul_start, mul_done;

    assign lfsr_nxt = lfsr_step(lfsr, LFSR_POLY);
    assign y        = {y3, y2, y1, y0};
    assign match    = ~(y ^ product);
    assign {a1, a0} = a_reg;
    assign {b1, b0} = b_reg;

    always_comb begin
        match_cnt = '0;
        for (int i = 0; i < VEC_W; i++) begin
            match_cnt = match_cnt + {6'b0, match[i]};
        end
    end

    // The multiplier takes b straight from the LFSR step so it can start during GEN_B.
    mul32_shift_add u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (a_reg),
        .b       (lfsr_nxt),
        .done    (mul_done),
        .product (product)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        mul_start = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = (num_vectors == 16'd0) ? S_DONE : S_GEN_A;
                end
            end
            S_GEN_A: state_nxt = S_GEN_B;
            S_GEN_B: begin
                mul_start = 1'b1;
                state_nxt = S_MUL;
            end
            S_MUL: begin
                if (mul_done) begin
                    state_nxt = S_CMP;
                end
            end
            S_CMP: state_nxt = (remaining == 16'd1) ? S_DONE : S_GEN_A;
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr        <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            remaining   <= '0;
            score       <= '0;
            exact_count <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        lfsr        <= (seed == 32'h0) ? 32'h1 : seed;
                        remaining   <= num_vectors;
                        score       <= '0;
                        exact_count <= '0;
                    end
                end
                S_GEN_A: begin
                    lfsr  <= lfsr_nxt;
                    a_reg <= lfsr_nxt;
                end
                S_GEN_B: begin
                    lfsr  <= lfsr_nxt;
                    b_reg <= lfsr_nxt;
                end
                S_CMP: begin
                    score     <= score + {25'b0, match_cnt};
                    remaining <= remaining - 16'd1;
                    if (y == product) begin
                        exact_count <= exact_count + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
